edge_detect_multi: RTL and testbench
====================================

Name: edge_detect_multi

Overview:
- Parametrised, multi-channel successor to the single-channel falling-edge trigger.
- Each channel of `tin` passes through a configurable synchroniser, then a programmable debounce/glitch filter.
- A per-channel mode selects which filtered edges (rise/fall/both/none) produce a one-cycle pulse and set a sticky flag.
- Sits between asynchronous comparator/temperature-alarm inputs and the ADC control FSM. All processing is gated by the PLL `locked` qualifier.

Parameters:
- N_CH, 4, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- FILT_W, 4, width of the debounce length field and per-channel counters (>=1).

Ports:
- clk  input  1  system clock.
- nrst  input  1  reset, asynchronous, active-low.
- locked  input  1  clock-valid qualifier; filter/edge logic advances only when high.
- tin  input  N_CH  asynchronous raw inputs, bit i = channel i.
- mode  input  2*N_CH  per-channel edge select; bits [2i+1:2i] encode 00 off, 01 rise, 10 fall, 11 both.
- filt_len  input  FILT_W  shared debounce length k; a change must persist k+1 sampled cycles.
- clr  input  N_CH  per-channel sticky clear, sampled on clk.
- pulse  output  N_CH  one-cycle registered edge pulse per channel.
- level  output  N_CH  registered filtered level per channel.
- sticky  output  N_CH  per-channel latched edge flag.
- any_sticky  output  1  OR-reduction of sticky, registered.

Behaviour:
- Reset (nrst low, async): sync chains, level, pulse, sticky, any_sticky and counters all go to 0.
- Synchroniser:
  - Shifts every clk regardless of `locked`.
  - `s_i` is the last stage output.
- Debounce, per channel, only when `locked`=1:
  - If s_i == level_i: cnt_i <= 0.
  - Else if cnt_i == filt_len: level_i <= s_i and cnt_i <= 0. This is the update event.
  - Else: cnt_i <= cnt_i+1.
- filt_len=0: level follows s_i one cycle later, with no filtering.
- Glitch rejection: a pulse on s_i shorter than filt_len+1 cycles produces no level change, and the counter restarts.
- filt_len changes mid-count: the comparison uses the current value. If cnt_i already exceeds the new filt_len, cnt_i keeps incrementing and wraps modulo 2^FILT_W; there is no special handling.
- pulse_i:
  - Registered; high for exactly the cycle in which level_i shows the new value.
  - Requires an update event and mode match: rise = 0->1, fall = 1->0, both = either, off = never.
  - Otherwise 0.
- Latency: a tin_i change stable from before edge 0 produces pulse_i/level_i after edge SYNC_STAGES+filt_len+1.
- mode affects pulse only; level tracks in all modes. A mode change applies from the next update event; no retro pulses.
- locked=0:
  - cnt, level and sticky are held.
  - pulse is forced to 0 from the next edge.
  - clr is still honoured.
  - When locked returns high, a pending difference between s_i and level_i restarts counting from the held cnt_i.
- sticky_i:
  - Set on any cycle where the pulse condition is true.
  - Cleared by clr_i.
  - Simultaneous set and clr: set wins, and sticky stays 1.
- any_sticky: registered OR of next-state sticky, so it aligns with sticky.
- Out of reset with tin_i held high: level_i rises after SYNC_STAGES+filt_len+1 locked cycles and a rise pulse is generated (intentional power-up event).
- Channels are fully independent; simultaneous edges on all channels each pulse in the same cycle.

Test Plan:
- Defaults, filt_len=0, mode ch0=10, locked=1: tin[0] 1->0 -> pulse[0] high for 1 cycle exactly 3 cycles after the change; sticky[0]=1 and any_sticky=1 in the same cycle.
- filt_len=3, mode=11: a 3-cycle high glitch on tin[1] -> no pulse and level[1] stays 0. A 4-cycle-stable high -> pulse[1] at 2+3+1=6 cycles; a later low edge gives a second pulse.
- locked=0 for 10 cycles while tin[2] rises (mode 01):
  - No pulse and level[2]=0 throughout.
  - Raise locked -> pulse[2] appears filt_len+1 cycles later.
  - clr[2] asserted while unlocked clears sticky[2].
- Simultaneous set/clear: clr[3]=1 in the same cycle as pulse condition on ch3 -> sticky[3]=1. Next cycle clr[3]=1 alone -> sticky[3]=0, any_sticky=0 if no other flags.
- mode=00 on ch0 with edges -> level[0] toggles, pulse[0]=0, sticky[0]=0. Switch to 01 -> the next rise pulses.
- nrst asserted mid-count and mid-pulse -> all outputs 0 immediately (asynchronous). With tin=4'hF after release -> all four channels pulse together (mode 01) after SYNC_STAGES+filt_len+1 cycles.

Source files
------------

// File: rtl/edge_detect_multi.sv
// ============================================================================
// Module      : edge_detect_multi
// Description : Multi-channel synchronised, debounced edge detector with
//               per-channel edge-mode select, one-cycle pulses and sticky flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_detect_multi #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                locked,
  input  logic [N_CH-1:0]     tin,
  input  logic [2*N_CH-1:0]   mode,
  input  logic [FILT_W-1:0]   filt_len,
  input  logic [N_CH-1:0]     clr,
  output logic [N_CH-1:0]     pulse,
  output logic [N_CH-1:0]     level,
  output logic [N_CH-1:0]     sticky,
  output logic                any_sticky
);

  localparam logic [1:0] C_MODE_RISE = 2'b01;
  localparam logic [1:0] C_MODE_FALL = 2'b10;
  localparam logic [1:0] C_MODE_BOTH = 2'b11;

  logic [SYNC_STAGES-1:0][N_CH-1:0] r_sync;
  logic [N_CH-1:0][FILT_W-1:0]      r_cnt;
  logic [N_CH-1:0]                  r_level;
  logic [N_CH-1:0]                  r_pulse;
  logic [N_CH-1:0]                  r_sticky;
  logic                             r_any_sticky;

  logic [N_CH-1:0]                  w_s;
  logic [N_CH-1:0][FILT_W-1:0]      w_cnt_nxt;
  logic [N_CH-1:0]                  w_level_nxt;
  logic [N_CH-1:0]                  w_set;
  logic [N_CH-1:0]                  w_sticky_nxt;

  // Synchroniser runs free of the locked qualifier so it is already settled
  // when the clock becomes valid.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], tin};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_set       = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (locked) begin
        if (w_s[i] == r_level[i]) begin
          w_cnt_nxt[i] = '0;
        end else if (r_cnt[i] == filt_len) begin
          w_level_nxt[i] = w_s[i];
          w_cnt_nxt[i]   = '0;
          case (mode[2*i +: 2])
            C_MODE_RISE: w_set[i] = w_s[i];
            C_MODE_FALL: w_set[i] = ~w_s[i];
            C_MODE_BOTH: w_set[i] = 1'b1;
            default:     w_set[i] = 1'b0;
          endcase
        end else begin
          // A shrunken filt_len below the running count simply lets it wrap.
          w_cnt_nxt[i] = r_cnt[i] + FILT_W'(1);
        end
      end
    end
  end

  // Set has priority over clear so an edge coinciding with clr is not lost.
  assign w_sticky_nxt = w_set | (r_sticky & ~clr);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt        <= '0;
      r_level      <= '0;
      r_pulse      <= '0;
      r_sticky     <= '0;
      r_any_sticky <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_level      <= w_level_nxt;
      r_pulse      <= w_set;
      r_sticky     <= w_sticky_nxt;
      r_any_sticky <= |w_sticky_nxt;
    end
  end

  assign pulse      = r_pulse;
  assign level      = r_level;
  assign sticky     = r_sticky;
  assign any_sticky = r_any_sticky;

endmodule

`default_nettype wire

// File: tb/tb_edge_detect_multi.sv
// ============================================================================
// Module      : tb_edge_detect_multi
// Description : Directed vector bench for edge_detect_multi (default params).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_edge_detect_multi;

  logic       clk;
  logic       nrst;
  logic       locked;
  logic [3:0] tin;
  logic [7:0] mode;
  logic [3:0] filt_len;
  logic [3:0] clr;
  logic [3:0] pulse;
  logic [3:0] level;
  logic [3:0] sticky;
  logic       any_sticky;

  int checks = 0;
  int errors = 0;

  edge_detect_multi #(
    .N_CH        (4),
    .SYNC_STAGES (2),
    .FILT_W      (4)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .locked     (locked),
    .tin        (tin),
    .mode       (mode),
    .filt_len   (filt_len),
    .clr        (clr),
    .pulse      (pulse),
    .level      (level),
    .sticky     (sticky),
    .any_sticky (any_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tin;
    logic [7:0] mode;
    logic [3:0] flen;
    logic       lck;
    logic [3:0] clr;
    logic [3:0] exp_pulse;
    logic [3:0] exp_level;
    logic [3:0] exp_sticky;
    logic       exp_any;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic [3:0] t, input logic [7:0] m,
                              input logic [3:0] f, input logic l,
                              input logic [3:0] c, input logic [3:0] ep,
                              input logic [3:0] el, input logic [3:0] es,
                              input logic ea);
    vec_t v;
    v.tin = t; v.mode = m; v.flen = f; v.lck = l; v.clr = c;
    v.exp_pulse = ep; v.exp_level = el; v.exp_sticky = es; v.exp_any = ea;
    vt.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive inputs, clock once, then sample 1 time unit after the edge.
  task automatic step(input string tag, input logic [3:0] t, input logic [7:0] m,
                      input logic [3:0] f, input logic l, input logic [3:0] c,
                      input logic [3:0] ep, input logic [3:0] el,
                      input logic [3:0] es, input logic ea);
    tin = t; mode = m; filt_len = f; locked = l; clr = c;
    @(posedge clk);
    #1;
    chk({tag, " pulse"},  pulse,  ep);
    chk({tag, " level"},  level,  el);
    chk({tag, " sticky"}, sticky, es);
    chk({tag, " any"},    {3'b000, any_sticky}, {3'b000, ea});
  endtask

  initial begin
    nrst = 1'b0; locked = 1'b1; tin = '0; mode = '0; filt_len = '0; clr = '0;

    // Fall mode on ch0, no filtering: pulse 3 edges after the change.
    add(4'h0, 8'h02, 4'd0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    add(4'h1, 8'h02, 4'd0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    add(4'h1, 8'h02, 4'd0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    add(4'h1, 8'h02, 4'd0, 1, 4'h0, 4'h0, 4'h1, 4'h0, 0);
    add(4'h1, 8'h02, 4'd0, 1, 4'h0, 4'h0, 4'h1, 4'h0, 0);
    add(4'h0, 8'h02, 4'd0, 1, 4'h0, 4'h0, 4'h1, 4'h0, 0);
    add(4'h0, 8'h02, 4'd0, 1, 4'h0, 4'h0, 4'h1, 4'h0, 0);
    add(4'h0, 8'h02, 4'd0, 1, 4'h0, 4'h1, 4'h0, 4'h1, 1);
    add(4'h0, 8'h02, 4'd0, 1, 4'h0, 4'h0, 4'h0, 4'h1, 1);
    add(4'h0, 8'h02, 4'd0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 0);
    // filt_len=3, both edges on ch1: 3-cycle glitch is rejected.
    for (int i = 0; i < 3; i++) add(4'h2, 8'h0C, 4'd3, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 4; i++) add(4'h0, 8'h0C, 4'd3, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    // Stable high: pulse on the 6th edge.
    for (int i = 0; i < 5; i++) add(4'h2, 8'h0C, 4'd3, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    add(4'h2, 8'h0C, 4'd3, 1, 4'h0, 4'h2, 4'h2, 4'h2, 1);
    add(4'h2, 8'h0C, 4'd3, 1, 4'h0, 4'h0, 4'h2, 4'h2, 1);
    for (int i = 0; i < 5; i++) add(4'h0, 8'h0C, 4'd3, 1, 4'h0, 4'h0, 4'h2, 4'h2, 1);
    add(4'h0, 8'h0C, 4'd3, 1, 4'h0, 4'h2, 4'h0, 4'h2, 1);
    add(4'h0, 8'h0C, 4'd3, 1, 4'h0, 4'h0, 4'h0, 4'h2, 1);
    add(4'h0, 8'h0C, 4'd3, 1, 4'h2, 4'h0, 4'h0, 4'h0, 0);
    // Mode off on ch0: level tracks, no pulse; then rise mode pulses.
    add(4'h1, 8'h00, 4'd0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    add(4'h1, 8'h00, 4'd0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    add(4'h1, 8'h00, 4'd0, 1, 4'h0, 4'h0, 4'h1, 4'h0, 0);
    add(4'h0, 8'h00, 4'd0, 1, 4'h0, 4'h0, 4'h1, 4'h0, 0);
    add(4'h0, 8'h00, 4'd0, 1, 4'h0, 4'h0, 4'h1, 4'h0, 0);
    add(4'h0, 8'h00, 4'd0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    add(4'h1, 8'h01, 4'd0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    add(4'h1, 8'h01, 4'd0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    add(4'h1, 8'h01, 4'd0, 1, 4'h0, 4'h1, 4'h1, 4'h1, 1);
    add(4'h1, 8'h01, 4'd0, 1, 4'h0, 4'h0, 4'h1, 4'h1, 1);
    add(4'h1, 8'h01, 4'd0, 1, 4'h1, 4'h0, 4'h1, 4'h0, 0);

    #2;
    chk("reset pulse",  pulse,  4'h0);
    chk("reset level",  level,  4'h0);
    chk("reset sticky", sticky, 4'h0);
    chk("reset any",    {3'b000, any_sticky}, 4'h0);
    #4 nrst = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      step($sformatf("vec%0d", i), vt[i].tin, vt[i].mode, vt[i].flen, vt[i].lck,
           vt[i].clr, vt[i].exp_pulse, vt[i].exp_level, vt[i].exp_sticky,
           vt[i].exp_any);
    end

    // Unlocked while ch2 rises: nothing moves until locked returns.
    for (int i = 0; i < 10; i++)
      step($sformatf("unlk%0d", i), 4'h5, 8'h10, 4'd2, 0, 4'h0, 4'h0, 4'h1, 4'h0, 0);
    step("relock0", 4'h5, 8'h10, 4'd2, 1, 4'h0, 4'h0, 4'h1, 4'h0, 0);
    step("relock1", 4'h5, 8'h10, 4'd2, 1, 4'h0, 4'h0, 4'h1, 4'h0, 0);
    step("relock2", 4'h5, 8'h10, 4'd2, 1, 4'h0, 4'h4, 4'h5, 4'h4, 1);
    step("unlk_hold", 4'h5, 8'h10, 4'd2, 0, 4'h0, 4'h0, 4'h5, 4'h4, 1);
    step("unlk_clr",  4'h5, 8'h10, 4'd2, 0, 4'h4, 4'h0, 4'h5, 4'h0, 0);

    // Set and clear in the same cycle on ch3: set wins.
    step("simul0", 4'hD, 8'h50, 4'd0, 1, 4'h0, 4'h0, 4'h5, 4'h0, 0);
    step("simul1", 4'hD, 8'h50, 4'd0, 1, 4'h0, 4'h0, 4'h5, 4'h0, 0);
    step("simul2", 4'hD, 8'h50, 4'd0, 1, 4'h8, 4'h8, 4'hD, 4'h8, 1);
    step("simul3", 4'hD, 8'h50, 4'd0, 1, 4'h8, 4'h0, 4'hD, 4'h0, 0);

    // Async reset right while a multi-channel pulse is showing.
    step("prerst0", 4'h0, 8'hFF, 4'd0, 1, 4'h0, 4'h0, 4'hD, 4'h0, 0);
    step("prerst1", 4'h0, 8'hFF, 4'd0, 1, 4'h0, 4'h0, 4'hD, 4'h0, 0);
    step("prerst2", 4'h0, 8'hFF, 4'd0, 1, 4'h0, 4'hD, 4'h0, 4'hD, 1);
    nrst = 1'b0;
    #2;
    chk("arst pulse",  pulse,  4'h0);
    chk("arst level",  level,  4'h0);
    chk("arst sticky", sticky, 4'h0);
    chk("arst any",    {3'b000, any_sticky}, 4'h0);
    tin = 4'hF; mode = 8'h55;
    @(posedge clk);
    #1;
    chk("rst_held level", level, 4'h0);
    nrst = 1'b1;
    step("post0", 4'hF, 8'h55, 4'd0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    step("post1", 4'hF, 8'h55, 4'd0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    step("post2", 4'hF, 8'h55, 4'd0, 1, 4'h0, 4'hF, 4'hF, 4'hF, 1);
    step("post3", 4'hF, 8'h55, 4'd0, 1, 4'h0, 4'h0, 4'hF, 4'hF, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
